// File: rtl/waveform_analyzer.sv
// Measures period, min, max and peak-to-peak of an 8-bit sample stream, using hysteretic rising-crossing detection.
// Optional macro WAVEFORM_ANALYZER_AVG4_EN: period_out becomes the mean of the last four periods.
module waveform_analyzer #(
    parameter int CNT_W  = 16,
    parameter int THRESH = 64,
    parameter int HYST   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic             clear,
    output logic [CNT_W-1:0] period_out,
    output logic [7:0]       vmin,
    output logic [7:0]       vmax,
    output logic [7:0]       p2p,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [7:0]       LO      = 8'(THRESH - HYST);
    localparam logic [7:0]       HI      = 8'(THRESH + HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       run_min_q, run_min_d;
    logic [7:0]       run_max_q, run_max_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       vmin_q, vmin_d;
    logic [7:0]       vmax_q, vmax_d;
    logic [7:0]       p2p_q, p2p_d;
    logic             mv_q, mv_d;
    logic             timeout_q, timeout_d;
    logic             crossing;

`ifdef WAVEFORM_ANALYZER_AVG4_EN
    localparam int SUM_W = CNT_W + 2;
    logic [3:0][CNT_W-1:0] hist_q, hist_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [1:0]            nmeas_q, nmeas_d;
`endif

    // Uses the armed flag from before this sample's own update
    assign crossing = armed_q && (sample_in >= HI);

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        period_d  = period_q;
        vmin_d    = vmin_q;
        vmax_d    = vmax_q;
        p2p_d     = p2p_q;
        mv_d      = 1'b0;
        timeout_d = timeout_q;
`ifdef WAVEFORM_ANALYZER_AVG4_EN
        hist_d    = hist_q;
        sum_d     = sum_q;
        nmeas_d   = nmeas_q;
`endif
        if (clear) begin
            state_d   = IDLE;
            armed_d   = 1'b0;
            cnt_d     = '0;
            run_min_d = 8'hFF;
            run_max_d = 8'h00;
            period_d  = '0;
            vmin_d    = 8'h00;
            vmax_d    = 8'h00;
            p2p_d     = 8'h00;
            timeout_d = 1'b0;
`ifdef WAVEFORM_ANALYZER_AVG4_EN
            hist_d    = '0;
            sum_d     = '0;
            nmeas_d   = '0;
`endif
        end else if (sample_valid) begin
            if (crossing)
                armed_d = 1'b0;
            else if (sample_in <= LO)
                armed_d = 1'b1;

            if (crossing) begin
                // The crossing sample opens the new period
                state_d   = RUN;
                cnt_d     = CNT_ONE;
                run_min_d = sample_in;
                run_max_d = sample_in;
                if (state_q == RUN) begin
`ifdef WAVEFORM_ANALYZER_AVG4_EN
                    sum_d  = sum_q - SUM_W'(hist_q[3]) + SUM_W'(cnt_q);
                    hist_d = {hist_q[2:0], cnt_q};
                    if (nmeas_q == 2'd3) begin
                        period_d = sum_d[SUM_W-1:2];
                        vmin_d   = run_min_q;
                        vmax_d   = run_max_q;
                        p2p_d    = run_max_q - run_min_q;
                        mv_d     = 1'b1;
                    end else begin
                        nmeas_d = nmeas_q + 2'd1;
                    end
`else
                    period_d = cnt_q;
                    vmin_d   = run_min_q;
                    vmax_d   = run_max_q;
                    p2p_d    = run_max_q - run_min_q;
                    mv_d     = 1'b1;
`endif
                end
            end else if (state_q == RUN) begin
                if (cnt_q == CNT_MAX) begin
                    // Period too long to count: give up lock, keep last results
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    armed_d   = 1'b0;
`ifdef WAVEFORM_ANALYZER_AVG4_EN
                    hist_d    = '0;
                    sum_d     = '0;
                    nmeas_d   = '0;
`endif
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    run_min_d = (sample_in < run_min_q) ? sample_in : run_min_q;
                    run_max_d = (sample_in > run_max_q) ? sample_in : run_max_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            run_min_q <= 8'hFF;
            run_max_q <= 8'h00;
            period_q  <= '0;
            vmin_q    <= 8'h00;
            vmax_q    <= 8'h00;
            p2p_q     <= 8'h00;
            mv_q      <= 1'b0;
            timeout_q <= 1'b0;
`ifdef WAVEFORM_ANALYZER_AVG4_EN
            hist_q    <= '0;
            sum_q     <= '0;
            nmeas_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            period_q  <= period_d;
            vmin_q    <= vmin_d;
            vmax_q    <= vmax_d;
            p2p_q     <= p2p_d;
            mv_q      <= mv_d;
            timeout_q <= timeout_d;
`ifdef WAVEFORM_ANALYZER_AVG4_EN
            hist_q    <= hist_d;
            sum_q     <= sum_d;
            nmeas_q   <= nmeas_d;
`endif
        end
    end

    assign period_out = period_q;
    assign vmin       = vmin_q;
    assign vmax       = vmax_q;
    assign p2p        = p2p_q;
    assign meas_valid = mv_q;
    assign locked     = (state_q == RUN);
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Random and directed stimulus for waveform_analyzer, checked every cycle against a sample-queue model.
module tb_waveform_analyzer;
    localparam int CW   = 9;
    localparam int TH   = 64;
    localparam int HY   = 8;
    localparam int LO   = TH - HY;
    localparam int HI   = TH + HY;
    localparam int MAXP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    sample_in = 8'h00;
    logic          sample_valid = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] period_out;
    logic [7:0]    vmin, vmax, p2p;
    logic          meas_valid, locked, timeout;

    waveform_analyzer #(.CNT_W(CW), .THRESH(TH), .HYST(HY)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .clear(clear), .period_out(period_out), .vmin(vmin), .vmax(vmax), .p2p(p2p),
        .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: current period kept as the list of its samples; results derived from that list
    bit          m_run, m_armed, m_cross;
    byte unsigned q[$];
    int          e_period, e_vmin, e_vmax, e_p2p;
    bit          e_mv, e_to;

    function automatic void m_reset();
        m_run = 0; m_armed = 0; q.delete();
        e_period = 0; e_vmin = 0; e_vmax = 0; e_p2p = 0; e_mv = 0; e_to = 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else begin
            e_mv = 0;
            if (clear) m_reset();
            else if (sample_valid) begin
                m_cross = m_armed && (int'(sample_in) >= HI);
                if (m_cross) begin
                    if (m_run) begin
                        e_period = q.size();
                        e_vmin = 255; e_vmax = 0;
                        foreach (q[i]) begin
                            if (q[i] < e_vmin) e_vmin = q[i];
                            if (q[i] > e_vmax) e_vmax = q[i];
                        end
                        e_p2p = e_vmax - e_vmin;
                        e_mv = 1;
                    end
                    m_run = 1; q.delete(); q.push_back(sample_in); m_armed = 0;
                end else if (m_run && q.size() == MAXP) begin
                    e_to = 1; m_run = 0; q.delete(); m_armed = 0;
                end else begin
                    if (m_run) q.push_back(sample_in);
                    if (int'(sample_in) <= LO) m_armed = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("period_out", period_out, e_period);
        chk("vmin", vmin, e_vmin);
        chk("vmax", vmax, e_vmax);
        chk("p2p", p2p, e_p2p);
        chk("meas_valid", meas_valid, e_mv);
        chk("locked", locked, m_run);
        chk("timeout", timeout, e_to);
    end

    int cyc = 0;
    int mv_cnt = 0, mv_last = 0, mv_prev = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (meas_valid === 1'b1) begin
        mv_cnt++; mv_prev = mv_last; mv_last = cyc;
    end

    task automatic drive(input bit v, input logic [7:0] s);
        sample_valid = v; sample_in = s;
        @(posedge clk); #2;
    endtask

    task automatic do_clear();
        clear = 1'b1; drive(1'b1, 8'd200); clear = 1'b0;
    endtask

    function automatic logic [7:0] sq(input int k);
        return ((k / 128) % 2) ? 8'd255 : 8'd0;
    endfunction

    function automatic logic [7:0] triv(input int k);
        int j;
        j = k % 256;
        return (j < 128) ? 8'(j) : 8'(255 - j);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period_out, 0);
        chk({tag, "_vmax"}, vmax, 0);
        chk({tag, "_p2p"}, p2p, 0);
        chk({tag, "_mv"}, meas_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int w;
        #1 rst = 1'b0;
        @(posedge clk); #2;
        chk_zero("rst");
        rst = 1'b1;

        // Square wave: 4 measurements of 256
        mv_cnt = 0;
        for (int k = 0; k < 1280; k++) begin
            drive(1'b1, sq(k));
            if (k == 127) chk("sq_locked_pre", locked, 0);
            if (k == 128) chk("sq_locked_post", locked, 1);
        end
        chk("sq_mv_cnt", mv_cnt, 4);
        chk("sq_spacing", mv_last - mv_prev, 256);
        chk("sq_period", period_out, 256);
        chk("sq_vmin", vmin, 0);
        chk("sq_vmax", vmax, 255);
        chk("sq_p2p", p2p, 255);

        // Triangle 0..127..0
        do_clear();
        chk_zero("clr");
        mv_cnt = 0;
        for (int k = 0; k < 1024; k++) begin
            drive(1'b1, triv(k));
            if (k == 72) chk("tri_locked", locked, 1);
        end
        chk("tri_mv_cnt", mv_cnt, 3);
        chk("tri_period", period_out, 256);
        chk("tri_vmin", vmin, 0);
        chk("tri_vmax", vmax, 127);
        chk("tri_p2p", p2p, 127);

        // Square with valid every other clock; invalid cycles carry junk
        do_clear();
        mv_cnt = 0;
        for (int k = 0; k < 1280; k++) begin
            drive(1'b1, sq(k));
            drive(1'b0, 8'($urandom_range(0, 255)));
        end
        chk("half_mv_cnt", mv_cnt, 4);
        chk("half_spacing", mv_last - mv_prev, 512);
        chk("half_period", period_out, 256);

        // Random: alternating uniform and random-walk segments, random gaps and clears
        do_clear();
        w = 64;
        for (int k = 0; k < 4000; k++) begin
            logic [7:0] s;
            w = w + $urandom_range(0, 24) - 12;
            if (w < 0) w = 0;
            if (w > 255) w = 255;
            s = ((k / 500) % 2) ? 8'(w) : 8'($urandom_range(0, 255));
            clear = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 3) != 0, s);
            clear = 1'b0;
        end

        // Overflow: one measurement, then held high until the counter saturates
        do_clear();
        for (int k = 0; k < 512; k++) drive(1'b1, sq(k));
        for (int j = 0; j < 383; j++) drive(1'b1, 8'd255);
        chk("ovf_pre_timeout", timeout, 0);
        chk("ovf_pre_locked", locked, 1);
        drive(1'b1, 8'd255);
        chk("ovf_timeout", timeout, 1);
        chk("ovf_locked", locked, 0);
        chk("ovf_hold_period", period_out, 256);
        chk("ovf_hold_vmax", vmax, 255);
        chk("ovf_hold_p2p", p2p, 255);
        for (int j = 0; j < 20; j++) drive(1'b1, 8'd255);
        chk("ovf_sticky", timeout, 1);
        do_clear();
        chk("ovf_clr_timeout", timeout, 0);

        // Reset mid-period
        for (int k = 0; k < 600; k++) drive(1'b1, sq(k));
        rst = 1'b0;
        #1 chk_zero("rst_mid");
        @(posedge clk); #2;
        rst = 1'b1;
        mv_cnt = 0;
        for (int k = 0; k < 512; k++) begin
            drive(1'b1, sq(k));
            if (k == 383) chk("rst_no_mv_early", mv_cnt, 0);
            if (k == 384) begin
                chk("rst_first_mv", meas_valid, 1);
                chk("rst_first_period", period_out, 256);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
